uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, 8N1 frame constants,
// and the clocks-per-bit calculation reused by the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int calcDiv(input int clkHz, input int baudRate);
        return clkHz / baudRate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the level
// count so the wrapping read and write pointers can be equal in both cases.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_popData,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depthCheck
        $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_popData = r_mem[r_rdPtr];
    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush && !reset) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a sync_fifo and are shifted
// out LSB first, each bit lasting CLK_HZ/BAUDRATE clocks.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUDRATE   = 25000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            uart_tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int DIV   = calcDiv(CLK_HZ, BAUDRATE);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_divCheck
        $fatal(1, "uart_tx_fifo: CLK_HZ/BAUDRATE must be at least 2");
    end

    tx_state_t            r_state;
    tx_state_t            w_stateNext;
    logic [CNT_W-1:0]     r_baudCnt;
    logic [CNT_W-1:0]     w_baudNext;
    logic [2:0]           r_bitIdx;
    logic [2:0]           w_bitNext;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic                 r_tx;
    logic                 w_txNext;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baudDone;
    logic [7:0]           w_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (in_valid),
        .i_pushData (in_data),
        .i_pop      (w_pop),
        .o_popData  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fifo_level)
    );

    assign in_ready   = !w_full;
    assign uart_tx    = r_tx;
    assign busy       = (r_state != ST_IDLE) || (fifo_level != '0);
    assign w_baudDone = (r_baudCnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_tx      <= STOP_BIT;
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudNext;
            r_bitIdx  <= w_bitNext;
            r_shift   <= w_shiftNext;
            r_tx      <= w_txNext;
        end
    end

    // The line level for the next bit is computed here so uart_tx comes straight from r_tx.
    always_comb begin
        w_stateNext = r_state;
        w_baudNext  = r_baudCnt;
        w_bitNext   = r_bitIdx;
        w_shiftNext = r_shift;
        w_txNext    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baudNext = '0;
                w_bitNext  = '0;
                w_txNext   = STOP_BIT;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_head;
                    w_txNext    = START_BIT;
                    w_stateNext = ST_START;
                end
            end
            ST_START: begin
                if (w_baudDone) begin
                    w_baudNext  = '0;
                    w_txNext    = r_shift[0];
                    w_stateNext = ST_DATA;
                end else begin
                    w_baudNext = r_baudCnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baudDone) begin
                    w_baudNext = '0;
                    if (r_bitIdx == 3'(DATA_BITS - 1)) begin
                        w_bitNext   = '0;
                        w_txNext    = STOP_BIT;
                        w_stateNext = ST_STOP;
                    end else begin
                        w_bitNext   = r_bitIdx + 3'd1;
                        w_shiftNext = r_shift >> 1;
                        w_txNext    = r_shift[1];
                    end
                end else begin
                    w_baudNext = r_baudCnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baudDone) begin
                    w_baudNext = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_head;
                        w_txNext    = START_BIT;
                        w_stateNext = ST_START;
                    end else begin
                        w_txNext    = STOP_BIT;
                        w_stateNext = ST_IDLE;
                    end
                end else begin
                    w_baudNext = r_baudCnt + CNT_W'(1);
                end
            end
            default: begin
                w_txNext    = STOP_BIT;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

endmodule
